// File: rtl/pc_fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_seq_pkg
// Brief   : Shared types and constants for the PC / fetch sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package pc_fetch_seq_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // PC arithmetic is modulo 2^PC_W; the truncation is intentional.
  function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] a,
                                             input logic [PC_W-1:0] b);
    return a + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module  : pc_next_sel
// Brief   : Combinational next-PC priority select (redirect > branch > seq).
// Revision: 1.0 - initial release
// ============================================================================
module pc_next_sel
  import pc_fetch_seq_pkg::*;
#(
  parameter int PC_INC = 2
) (
  input  logic            redir_sel,
  input  logic [PC_W-1:0] redir_pc,
  input  logic            branch_sel,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] next_pc,
  output logic [PC_W-1:0] seq_pc
);

  localparam logic [PC_W-1:0] c_inc = PC_W'(PC_INC);

  logic [PC_W-1:0] w_seq;

  assign w_seq  = pc_add(pc, c_inc);
  assign seq_pc = w_seq;

  always_comb begin
    next_pc = w_seq;
    if (redir_sel) begin
      next_pc = redir_pc;
    end else if (branch_sel) begin
      next_pc = branch_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_seq
// Brief   : Program counter and single-outstanding fetch sequencer with
//           stall, branch, halt and flush redirect handling.
// Revision: 1.0 - initial release
// ============================================================================
module pc_fetch_seq
  import pc_fetch_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              PC_INC   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] pc_plus,
  output logic            halted
);

  localparam logic [PC_W-1:0] c_reset_plus = PC_W'(PC_INC);

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_instr;
  logic [PC_W-1:0] r_instr_pc;
  logic [PC_W-1:0] r_pc_plus;
  logic            r_redir_pending;
  logic [PC_W-1:0] r_redir_pc;

  logic            w_in_fetch;
  logic            w_redir_sel;
  logic [PC_W-1:0] w_redir_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_seq_pc;

  assign w_in_fetch  = (r_state == ST_FETCH);
  // A same-cycle flush target always beats a previously parked redirect.
  assign w_redir_sel = flush || (w_in_fetch && r_redir_pending);
  assign w_redir_pc  = flush ? flush_target : r_redir_pc;

  pc_next_sel #(
    .PC_INC        (PC_INC)
  ) u_pc_next_sel (
    .redir_sel     (w_redir_sel),
    .redir_pc      (w_redir_pc),
    .branch_sel    (branch_taken),
    .branch_target (branch_target),
    .pc            (r_pc),
    .next_pc       (w_next_pc),
    .seq_pc        (w_seq_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_pc            <= RESET_PC;
      r_instr         <= '0;
      r_instr_pc      <= '0;
      r_pc_plus       <= c_reset_plus;
      r_redir_pending <= 1'b0;
      r_redir_pc      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            if (flush || r_redir_pending) begin
              // Returned word belongs to the abandoned stream; refetch.
              r_pc            <= w_next_pc;
              r_redir_pending <= 1'b0;
            end else begin
              r_instr    <= imem_rdata;
              r_instr_pc <= r_pc;
              r_pc_plus  <= w_seq_pc;
              r_state    <= ST_ISSUE;
            end
          end else if (flush) begin
            // The request cannot be withdrawn, so park the redirect.
            r_redir_pending <= 1'b1;
            r_redir_pc      <= flush_target;
          end
        end
        ST_ISSUE: begin
          if (flush) begin
            r_pc    <= w_next_pc;
            r_state <= ST_FETCH;
          end else if (!stall) begin
            if (halt) begin
              r_state <= ST_HALTED;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_ISSUE);
  assign halted      = (r_state == ST_HALTED);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc_plus     = r_pc_plus;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_fetch_seq
// Brief   : Directed self-checking bench for pc_fetch_seq.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic        flush;
  logic [15:0] flush_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus;
  logic        halted;

  logic        ack_en;
  int          n_cmp;
  int          n_err;

  pc_fetch_seq #(
    .RESET_PC      (16'h0100),
    .PC_INC        (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .flush         (flush),
    .flush_target  (flush_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .pc_plus       (pc_plus),
    .halted        (halted)
  );

  // Memory model: acks whenever enabled, data is the address scrambled.
  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = imem_addr ^ 16'h5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    halt = 1'b0; flush = 1'b0; flush_target = '0; ack_en = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 16'h0100) begin n_err++; $display("FAIL reset_addr: got %h want 0100", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL reset_instr: got %h want 0000", instr); end
    n_cmp++; if (instr_pc !== 16'h0000) begin n_err++; $display("FAIL reset_instr_pc: got %h want 0000", instr_pc); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 16'h0100) begin n_err++; $display("FAIL first_addr: got %h want 0100", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [15:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 16'h0100 + 16'(2 * k);
      if (k != 0) @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_err++; $display("FAIL seq_fetch%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, a); end
      @(negedge clk);
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== a) begin n_err++; $display("FAIL seq_issue%0d: got valid=%b pc=%h want valid=1 pc=%h", k, instr_valid, instr_pc, a); end
      n_cmp++; if (instr !== (a ^ 16'h5A5A)) begin n_err++; $display("FAIL seq_instr%0d: got %h want %h", k, instr, a ^ 16'h5A5A); end
      n_cmp++; if (pc_plus !== a + 16'd2) begin n_err++; $display("FAIL seq_pc_plus%0d: got %h want %h", k, pc_plus, a + 16'd2); end
    end
  endtask

  // Entered while ISSUE of 0104 is on the outputs.
  task automatic test_branch();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0104 || instr !== 16'h5B5E) begin n_err++; $display("FAIL stall_hold%0d: got valid=%b pc=%h instr=%h want 1/0104/5b5e", k, instr_valid, instr_pc, instr); end
    end
    stall = 1'b0;
    @(negedge clk);
    branch_taken = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin n_err++; $display("FAIL branch_addr: got req=%b addr=%h want 1/0200", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL branch_valid: got %b want 0", instr_valid); end
  endtask

  // Entered in FETCH of 0200 with no ack yet taken.
  task automatic test_flush_fetch();
    ack_en = 1'b0; flush = 1'b1; flush_target = 16'h0300;
    @(negedge clk);
    flush = 1'b0; flush_target = 16'h0BAD;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin n_err++; $display("FAIL flush_hold1: got req=%b addr=%h want 1/0200", imem_req, imem_addr); end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin n_err++; $display("FAIL flush_hold2: got req=%b addr=%h want 1/0200", imem_req, imem_addr); end
    ack_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL flush_discard: got valid=%b want 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0300) begin n_err++; $display("FAIL flush_redir: got req=%b addr=%h want 1/0300", imem_req, imem_addr); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0300) begin n_err++; $display("FAIL flush_issue: got valid=%b pc=%h want 1/0300", instr_valid, instr_pc); end
  endtask

  // Entered in ISSUE of 0300; also covers ack coinciding with flush.
  task automatic test_flush_issue();
    flush = 1'b1; flush_target = 16'h0400; halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL flush_over_halt: got halted=%b want 0", halted); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0400) begin n_err++; $display("FAIL flush_issue_addr: got req=%b addr=%h want 1/0400", imem_req, imem_addr); end
    flush_target = 16'h0500;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0500) begin n_err++; $display("FAIL ack_flush_same: got valid=%b addr=%h want 0/0500", instr_valid, imem_addr); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0500) begin n_err++; $display("FAIL ack_flush_issue: got valid=%b pc=%h want 1/0500", instr_valid, instr_pc); end
  endtask

  // Entered in ISSUE of 0500.
  task automatic test_halt();
    flush = 1'b1; flush_target = 16'h0010;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0010) begin n_err++; $display("FAIL halt_setup: got valid=%b pc=%h want 1/0010", instr_valid, instr_pc); end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_enter: got halted=%b req=%b valid=%b want 1/0/0", halted, imem_req, instr_valid); end
    flush = 1'b1; flush_target = 16'h0700;
    repeat (4) @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL halt_sticky: got halted=%b req=%b want 1/0", halted, imem_req); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (halted !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 16'h0100) begin n_err++; $display("FAIL halt_reset: got halted=%b req=%b addr=%h want 0/0/0100", halted, imem_req, imem_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin n_err++; $display("FAIL halt_refetch: got req=%b addr=%h want 1/0100", imem_req, imem_addr); end
  endtask

  // Entered in FETCH of 0100 with ack enabled.
  task automatic test_wrap();
    @(negedge clk);
    flush = 1'b1; flush_target = 16'hFFFE;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (imem_addr !== 16'hFFFE) begin n_err++; $display("FAIL wrap_fetch: got %h want fffe", imem_addr); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFE || pc_plus !== 16'h0000) begin n_err++; $display("FAIL wrap_issue: got valid=%b pc=%h plus=%h want 1/fffe/0000", instr_valid, instr_pc, pc_plus); end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_flush_fetch();
    test_flush_issue();
    test_halt();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
